// File: rtl/usb_pkg.sv
// Shared USB datapath definitions: packetizer state encoding and burst sizing
// constants used by the TX packetizer and the reusable FIFO.
package usb_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_BURST = 2'd1,
    ST_ZLP   = 2'd2
  } pkt_state_e;

  // One USB3 bulk burst: 1024 bytes of 32-bit words.
  localparam int USB3_BURST_WORDS      = 256;
  localparam int DEFAULT_FLUSH_TIMEOUT = 1000;
  localparam int TX_WORD_W             = 32;

endpackage

// File: rtl/usb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is presented on
// rdata_o whenever empty_o is low; pop_i advances past it. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module usb_sync_fifo
  import usb_pkg::*;
#(
  parameter int WIDTH      = TX_WORD_W,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // Overflow and underflow requests are dropped rather than corrupting pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB TX packetizer: buffers 32-bit words from the personality mux and hands
// them to the FT601 interface in bursts of up to PKT_WORDS words, the last
// word flagged by out_last. Short bursts are closed by an inactivity timeout
// (counted from the last push) or by flush_req.
// Optional build macro USB_TX_ZLP_EN: after a burst of exactly PKT_WORDS with
// nothing following, emit one zero-length-packet marker beat on timeout/flush.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int DEPTH_LOG2    = 9,
  parameter int PKT_WORDS     = USB3_BURST_WORDS,
  parameter int FLUSH_TIMEOUT = DEFAULT_FLUSH_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush_req,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_zlp,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int CNT_W = $clog2(PKT_WORDS + 1);
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LVL_W-1:0] PKT_LVL = LVL_W'(PKT_WORDS);
  localparam logic [CNT_W-1:0] PKT_CNT = CNT_W'(PKT_WORDS);

  pkt_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;   // beats not yet handed off
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;     // beats not yet pulled from FIFO
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             flush_pend_q, flush_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;

  logic             push, pop;
  logic             fifo_full, fifo_empty, has_data;
  logic [31:0]      fifo_rdata;
  logic [LVL_W-1:0] fifo_level;
  logic             out_hs, timeout, zlp_armed;
  logic [CNT_W-1:0] burst_len;

`ifdef USB_TX_ZLP_EN
  logic zlp_flag_q, zlp_flag_d;     // last completed burst was full-size
  logic full_burst_q, full_burst_d; // burst in progress is full-size
  logic out_zlp_q, out_zlp_d;
`endif

  usb_sync_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign has_data  = !fifo_empty;
  assign out_hs    = out_valid_q && out_ready;
  assign timeout   = (timer_q == TMR_W'(FLUSH_TIMEOUT - 1));
  assign burst_len = (fifo_level >= PKT_LVL) ? PKT_CNT : CNT_W'(fifo_level);

`ifdef USB_TX_ZLP_EN
  assign zlp_armed = zlp_flag_q;
  assign out_zlp   = out_zlp_q;
  assign out_last  = out_valid_q &&
                     (((state_q == ST_BURST) && (burst_cnt_q == CNT_W'(1))) ||
                      (state_q == ST_ZLP));
`else
  assign zlp_armed = 1'b0;
  assign out_zlp   = 1'b0;
  assign out_last  = out_valid_q && (state_q == ST_BURST) && (burst_cnt_q == CNT_W'(1));
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = fifo_level;
  assign idle      = (state_q == ST_FILL) && !has_data && !flush_pend_q;

  // Next-state logic: burst start decision, output-register loading, timer.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    load_cnt_d   = load_cnt_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q || flush_req;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    pop          = 1'b0;
`ifdef USB_TX_ZLP_EN
    zlp_flag_d   = zlp_flag_q && !push;
    full_burst_d = full_burst_q;
    out_zlp_d    = out_zlp_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (has_data && ((fifo_level >= PKT_LVL) || timeout || flush_pend_q)) begin
          // The first word is loaded on the start cycle itself, so it is
          // visible on out_data one cycle later.
          state_d      = ST_BURST;
          burst_cnt_d  = burst_len;
          load_cnt_d   = burst_len - 1'b1;
          pop          = 1'b1;
          out_valid_d  = 1'b1;
          out_data_d   = fifo_rdata;
          timer_d      = '0;
          flush_pend_d = flush_req;
`ifdef USB_TX_ZLP_EN
          full_burst_d = (burst_len == PKT_CNT);
          out_zlp_d    = 1'b0;
`endif
        end
`ifdef USB_TX_ZLP_EN
        else if (!has_data && zlp_flag_q && !push && (timeout || flush_pend_q)) begin
          state_d      = ST_ZLP;
          out_valid_d  = 1'b1;
          out_zlp_d    = 1'b1;
          timer_d      = '0;
          flush_pend_d = flush_req;
        end
`endif
        else begin
          // Timer measures quiet time since the last push (or since the end
          // of a full burst when a ZLP may still be owed).
          if (push) begin
            timer_d = '0;
          end else if (has_data || zlp_armed) begin
            timer_d = timer_q + 1'b1;
          end else begin
            timer_d = '0;
          end
          // A flush with nothing buffered and nothing owed is a no-op.
          if (!has_data && !push && !zlp_armed) begin
            flush_pend_d = 1'b0;
          end
        end
      end
      ST_BURST: begin
        timer_d = '0;
        if (out_hs) begin
          burst_cnt_d = burst_cnt_q - 1'b1;
        end
        if ((load_cnt_q != '0) && (!out_valid_q || out_hs)) begin
          pop         = 1'b1;
          out_data_d  = fifo_rdata;
          out_valid_d = 1'b1;
          load_cnt_d  = load_cnt_q - 1'b1;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
        if (out_hs && (burst_cnt_q == CNT_W'(1))) begin
          state_d = ST_FILL;
`ifdef USB_TX_ZLP_EN
          zlp_flag_d = full_burst_q && !push;
`endif
        end
      end
`ifdef USB_TX_ZLP_EN
      ST_ZLP: begin
        timer_d = '0;
        if (out_hs) begin
          state_d     = ST_FILL;
          out_valid_d = 1'b0;
          out_zlp_d   = 1'b0;
          zlp_flag_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Control and output registers; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      burst_cnt_q  <= '0;
      load_cnt_q   <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      load_cnt_q   <= load_cnt_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

`ifdef USB_TX_ZLP_EN
  // Zero-length-packet bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zlp_flag_q   <= 1'b0;
      full_burst_q <= 1'b0;
      out_zlp_q    <= 1'b0;
    end else begin
      zlp_flag_q   <= zlp_flag_d;
      full_burst_q <= full_burst_d;
      out_zlp_q    <= out_zlp_d;
    end
  end
`endif

endmodule

// File: doc/usb_tx_packetizer.md
Name: usb_tx_packetizer

Overview:
- Sits directly downstream of the USB personality mux, between the mux TX output and the FT601 interface TX input.
- Buffers 32-bit TX words and groups them into bursts of up to PKT_WORDS words, each terminated by out_last.
- Flushes short bursts after an inactivity timeout or on an explicit flush request, so that short protocol replies reach the host promptly.
- Reports idle, letting the mux TX-drain phase complete cleanly.

Parameters:
- DEPTH_LOG2, 9, FIFO depth = 2^DEPTH_LOG2 words (512); must satisfy 2^DEPTH_LOG2 >= PKT_WORDS.
- PKT_WORDS, 256, maximum words per burst (1024 B, one USB3 bulk burst).
- FLUSH_TIMEOUT, 1000, number of idle clk cycles with data pending before a short burst is forced.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, 32, TX word from the personality mux.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, packetizer accepts a word this cycle.
- flush_req, input, 1, single-cycle pulse requesting immediate close of pending data.
- out_data, output, 32, word to the FT601 interface.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, FT601 interface accepts the word.
- out_last, output, 1, final word of the current burst; qualified by out_valid.
- out_zlp, output, 1, current beat is a zero-length-packet marker; out_data is don't-care.
- level, output, DEPTH_LOG2+1, current FIFO occupancy.
- idle, output, 1, FIFO empty, no burst in progress, no flush pending.

Behaviour:
- Handshakes: a transfer occurs on valid&&ready on either side. out_data, out_last and out_zlp stay stable while out_valid=1 and out_ready=0. in_ready = !full (combinational from level).
- Reset values: out_valid=0, out_last=0, out_zlp=0, out_data=0, level=0, idle=1, in_ready=1. State=ST_FILL, timer=0, flush_pending=0.
- Reset mid-burst discards all buffered data and the burst in progress. No partial burst is resumed.
- FIFO behaviour:
  - Registered-output FWFT. First word appears on out_data one cycle after a burst starts.
  - Simultaneous push and pop on the same cycle leaves level unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2. Full and empty are taken from the extra pointer bit.
- State machine:
  - ST_FILL:
    - timer increments each cycle with level>0 and no push; it clears on a push or when level=0.
    - Start a burst when level>=PKT_WORDS, OR (level>0 and timer==FLUSH_TIMEOUT-1), OR (level>0 and flush_pending).
    - On start: latch burst_cnt = min(level, PKT_WORDS), clear flush_pending and timer, go to ST_BURST.
  - ST_BURST:
    - Each out handshake decrements burst_cnt. out_last=1 when burst_cnt==1.
    - On the handshake of the last word, return to ST_FILL.
    - Pushes continue during a burst, but pushed words are not added to burst_cnt.
    - If level>=PKT_WORDS on return, the next burst starts the cycle after, with no idle gap beyond one cycle.
  - ST_ZLP (macro only): see Optional Feature.
- flush_req:
  - Sets flush_pending. A flush_req arriving during ST_BURST applies after that burst.
  - flush_req with level=0 in ST_FILL clears flush_pending; no beat is emitted unless the macro is enabled.
  - flush_req on the same cycle as the first push starts a burst of 1 word once the word is visible in level (next cycle).
- Timeout: FLUSH_TIMEOUT counts from the last push, not the first. Continuous trickle traffic below PKT_WORDS is therefore only flushed by the fill threshold or by flush_req.
- idle = (state==ST_FILL) && level==0 && !flush_pending. The mux drain logic observes this signal.

Optional Feature:
- Macro: USB_TX_ZLP_EN.
- Defined:
  - A 1-bit flag records that the last completed burst was exactly PKT_WORDS long.
  - If the flag is set and level==0, then a timeout (timer counting from burst end) or a flush_pending enters ST_ZLP.
  - ST_ZLP emits one beat with out_valid=1, out_zlp=1, out_last=1, then returns to ST_FILL and clears the flag.
  - The flag also clears on any push.
  - flush_req on empty with the flag clear still emits nothing.
- Undefined: out_zlp tied to 0, ST_ZLP and the flag are removed, and no beat is ever emitted without data.

Decomposition:
- Shared package usb_pkg:
  - Packetizer state encodings ST_FILL, ST_BURST, ST_ZLP.
  - USB3_BURST_WORDS=256.
  - Default FLUSH_TIMEOUT constant.
- One natural sub-module: usb_sync_fifo. It is a parameterised FWFT synchronous FIFO with push, pop, data, full, empty and level outputs, and it is reusable for the RX path.

Test Plan:
- Push 256 words 0..255 back-to-back with out_ready=1 -> one burst of 256 beats in order, out_last only on word 255, then idle=1.
- Push 3 words, then wait -> a burst of 3 starts exactly FLUSH_TIMEOUT cycles after the last push; out_last on the third word.
- Push 600 words with out_ready toggling 1/0 every cycle -> bursts of 256, 256, 88 (last one via timeout), no word lost or duplicated, and in_ready drops when level=512.
- Push 5 words then flush_req on the next cycle -> a burst of 5 starts within 2 cycles. A second flush_req with level=0 -> no beat, idle stays 1.
- Assert rst for 1 cycle during a burst with 100 words pending -> out_valid=0, level=0, idle=1 immediately; a subsequent push of 1 word is emitted alone after the timeout.
- With USB_TX_ZLP_EN defined: push exactly 256 words then flush_req -> 256-word burst followed by one out_zlp=1/out_last=1 beat. Without the macro: no extra beat.
